method_fetch: RTL and testbench
===============================

# method_fetch

Byte-stream fetch unit that feeds the MBR. It owns the program counter and issues byte reads to the method-area memory over a req/ack handshake. Returned bytes are buffered in a small prefetch queue, and the head byte is presented on `mem` with a valid flag; the MBR's read enable pops it. It sits between the external method-area memory and the MBR, replacing direct PC-to-memory addressing.

## Interface
- `ADDR_W`, 16: method-area byte address width.
- `DEPTH`, 4: prefetch queue entries, power of two, ≥2.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `c_bus`  in  32: new PC value, used when `pc_load`=1.
- `pc_load`  in  1: load PC from `c_bus[ADDR_W-1:0]` and flush the queue.
- `fetch`  in  1: MBR consumes the head byte (drive from the MBR's memory read enable).
- `mem`  out  8: head byte of the queue; feeds the MBR's `mem` input.
- `mem_valid`  out  1: `mem` holds a valid byte.
- `pc`  out  32: zero-extended address of the head byte / next byte to consume.
- `fetch_miss`  out  1: one-cycle pulse when `fetch`=1 while `mem_valid`=0.
- `mem_req`  out  1: read request to method-area memory.
- `mem_addr`  out  ADDR_W: request byte address.
- `mem_rdata`  in  8: read data, valid with `mem_ack`.
- `mem_ack`  in  1: request complete; `mem_rdata` valid.

## Operation
- **Reset (async, `rst_n`=0):**
  - outputs: `pc`=0, `mem`=8'h00, `mem_valid`=0, `fetch_miss`=0, `mem_req`=0, `mem_addr`=0
  - internal: queue empty, fetch address 0, discard flag clear.
  - Reset mid-transaction abandons the outstanding request with no further handshake.
- **State:**
  - queue: count 0..DEPTH, read/write pointers mod DEPTH
  - fetch address `fa`
  - outstanding flag `os`
  - discard flag `dc`
- **Request FSM (IDLE, WAIT):**
  - IDLE→WAIT when `count + (incoming ack ? 1 : 0) < DEPTH` after this cycle's pop. Drive `mem_req`=1 and `mem_addr`=`fa`, both registered.
  - WAIT holds `mem_req` and `mem_addr` stable until `mem_ack`.
  - On `mem_ack` in WAIT:
    - `dc`=0: write `mem_rdata` to the queue and set `fa`←`fa`+1, wrapping mod 2^ADDR_W.
    - `dc`=1: drop the data and clear `dc`.
    - Then stay in WAIT with the next address if space remains (back-to-back), else go to IDLE.
  - At most one request is outstanding, so the queue never overflows.
- **Consume:**
  - `fetch`=1 with `mem_valid`=1: pop, and `pc`←`pc`+1 (32-bit, wrapping).
  - `fetch`=1 with `mem_valid`=0: no state change; `fetch_miss`=1 for one cycle.
- **PC load:**
  - `pc`←{0, `c_bus[ADDR_W-1:0]`}, `fa`←same value, queue emptied, `mem_valid`→0.
  - If a request is outstanding (WAIT without an ack this cycle), set `dc`=1. `mem_req` stays high at the old address until ack, and that data is discarded. The first new-address request then issues on the cycle after that ack.
- **Simultaneous events:**
  - `pc_load` with `fetch`: load wins; no pop, no `fetch_miss`.
  - `pc_load` with `mem_ack`: the ack's data is discarded, `dc` is not set, and the next request goes to the new address.
  - `fetch` pop with `mem_ack` push on a full queue cannot occur. Pop and push on a non-full queue leave count unchanged.
- `mem` = queue[head] whenever `mem_valid`=1, and holds its last value when empty.

## Timing
- All outputs are registered. The MBR samples `mem` on posedge when its read enable is high, and `mem`/`mem_valid` are stable across that edge.
- Zero-wait memory (`mem_ack` high in the first cycle of `mem_req`):
  - `pc_load` at edge E → `mem_req` high after E → data written at E+1 → `mem_valid`=1 after E+1.
  - Sustained throughput is 1 byte/cycle.
- Memory with N wait cycles: each byte takes N+1 cycles; the queue absorbs MBR bursts of up to DEPTH bytes.
- `fetch_miss` is asserted for exactly the cycle after the offending edge.

## Test plan
- **Reset and fill:** zero-wait memory with byte[i]=i+8'h10, release reset, no fetch. → `mem_req` issues addresses 0,1,2,3, then drops (queue full, count=4); `mem`=8'h10, `pc`=0.
- **Streaming:** `fetch`=1 for 8 cycles from the full-queue state. → `mem` sequence 10,11,…,17 with no `fetch_miss`; `pc` ends at 8.
- **Flush with in-flight request:** 3-cycle wait memory; `pc_load` with `c_bus`=32'h0000_0100 while a request to addr 2 is outstanding. → addr 2 stays held until ack and its data is dropped; next `mem_addr`=16'h0100; first valid `mem`=byte[0x100], `pc`=32'h100.
- **Underflow:** 3-cycle wait memory, `pc_load`, then `fetch` on the next cycle. → `fetch_miss` pulses once; `pc` unchanged; the first byte is delivered intact later.
- **Wrap:** `pc_load` with `c_bus`=32'h0000_FFFE, fetch 4 bytes. → `mem_addr` sequence FFFE, FFFF, 0000, 0001; `pc` reads 0x10000 after the 2nd pop (32-bit `pc`) while `mem_addr` wraps.
- **Async reset mid-WAIT:** assert `rst_n`=0 mid-cycle during WAIT. → `mem_req`, `mem_valid` and `pc` clear immediately without waiting for a clock edge; after release, refill restarts from addr 0.

Source files
------------

// File: rtl/method_fetch.sv
// rtl/method_fetch.sv - PC-owning byte fetch unit with req/ack memory port and prefetch queue
// Feeds the MBR from a DEPTH-entry queue; at most one memory request outstanding.
module method_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       c_bus,
  input  logic              pc_load,
  input  logic              fetch,
  output logic [7:0]        mem,
  output logic              mem_valid,
  output logic [31:0]       pc,
  output logic              fetch_miss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        q_q [DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] fa_q, fa_d, mem_addr_q, mem_addr_d;
  logic [31:0]       pc_q, pc_d;
  logic [7:0]        mem_q, mem_d;
  logic              dc_q, dc_d, mem_req_q, mem_req_d;
  logic              mem_valid_q, mem_valid_d, fetch_miss_q, fetch_miss_d;
  logic              ack, pop, push, space;
  logic              unused_c_bus;

  assign unused_c_bus = ^c_bus[31:ADDR_W];

  always_comb begin
    ack          = (state_q == WAIT) && mem_ack;
    pop          = fetch && mem_valid_q && !pc_load;
    push         = ack && !dc_q && !pc_load;
    pc_d         = pc_q;
    fa_d         = fa_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    dc_d         = dc_q;
    fetch_miss_d = fetch && !mem_valid_q && !pc_load;

    if (pc_load) begin
      pc_d    = 32'(c_bus[ADDR_W-1:0]);
      fa_d    = c_bus[ADDR_W-1:0];
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      // An un-acked request in flight must have its data thrown away later.
      if (state_q == WAIT && !mem_ack) dc_d = 1'b1;
    end else begin
      if (pop) begin
        pc_d   = pc_q + 32'd1;
        rptr_d = rptr_q + PW'(1);
      end
      if (push) begin
        wptr_d = wptr_q + PW'(1);
        fa_d   = fa_q + ADDR_W'(1);
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    if (ack) dc_d = 1'b0;

    space      = count_d < (PW+1)'(DEPTH);
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (space) begin
          state_d    = WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fa_d;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (space) begin
            mem_addr_d = fa_d;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The incoming byte becomes the head when it lands in the slot rptr_d points at.
    mem_valid_d = (count_d != '0);
    mem_d       = mem_q;
    if (mem_valid_d) mem_d = (push && wptr_q == rptr_d) ? mem_rdata : q_q[rptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= 8'h00;
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      fa_q         <= '0;
      mem_addr_q   <= '0;
      pc_q         <= '0;
      mem_q        <= 8'h00;
      dc_q         <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      fetch_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push) q_q[wptr_q] <= mem_rdata;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      fa_q         <= fa_d;
      mem_addr_q   <= mem_addr_d;
      pc_q         <= pc_d;
      mem_q        <= mem_d;
      dc_q         <= dc_d;
      mem_req_q    <= mem_req_d;
      mem_valid_q  <= mem_valid_d;
      fetch_miss_q <= fetch_miss_d;
    end
  end

  assign mem        = mem_q;
  assign mem_valid  = mem_valid_q;
  assign pc         = pc_q;
  assign fetch_miss = fetch_miss_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_method_fetch.sv
// tb/tb_method_fetch.sv - directed self-checking bench for method_fetch
// Memory model acks after wait_n extra cycles; byte contents come from bmem().
module tb_method_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_bus = '0;
  logic        pc_load = 1'b0;
  logic        fetch = 1'b0;
  logic [7:0]  mem;
  logic        mem_valid;
  logic [31:0] pc;
  logic        fetch_miss;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;
  int wait_n = 0;
  int wcnt = 0;

  method_fetch #(.ADDR_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .c_bus(c_bus), .pc_load(pc_load), .fetch(fetch),
    .mem(mem), .mem_valid(mem_valid), .pc(pc), .fetch_miss(fetch_miss),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bmem(input logic [15:0] a);
    return a[7:0] + a[15:8] * 8'd3 + 8'h10;
  endfunction

  assign mem_ack   = mem_req && (wcnt == wait_n);
  assign mem_rdata = bmem(mem_addr);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic do_reset(input int w);
    rst_n = 1'b0; pc_load = 1'b0; fetch = 1'b0; wait_n = w;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 32'd0 || mem !== 8'h00 || mem_valid !== 1'b0 || fetch_miss !== 1'b0 ||
        mem_req !== 1'b0 || mem_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: pc=%h mem=%h valid=%b miss=%b req=%b addr=%h, required all zero",
               pc, mem, mem_valid, fetch_miss, mem_req, mem_addr);
    end
  endtask

  task automatic test_fill;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'(i)) begin
        failures++;
        $display("FAIL fill_addr[%0d]: req=%b addr=%h, required req=1 addr=%h", i, mem_req, mem_addr, 16'(i));
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || mem_valid !== 1'b1 || mem !== 8'h10 || pc !== 32'd0) begin
        failures++;
        $display("FAIL fill_full: req=%b valid=%b mem=%h pc=%h, required req=0 valid=1 mem=10 pc=0",
                 mem_req, mem_valid, mem, pc);
      end
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem !== 8'(8'h10 + i) || fetch_miss !== 1'b0 || pc !== 32'(i)) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b mem=%h miss=%b pc=%h, required valid=1 mem=%h miss=0 pc=%h",
                 i, mem_valid, mem, fetch_miss, pc, 8'(8'h10 + i), 32'(i));
      end
      fetch = (i < 8);
      @(negedge clk);
    end
    fetch = 1'b0;
  endtask

  task automatic test_flush;
    int n;
    int held;
    do_reset(3);
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === 16'h2) && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL flush_reach_addr2: timeout, addr=%h", mem_addr); end
    pc_load = 1'b1; c_bus = 32'h0000_0100;
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (pc !== 32'h100 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_load: pc=%h valid=%b, required pc=100 valid=0", pc, mem_valid);
    end
    held = 0;
    while (mem_req === 1'b1 && mem_addr === 16'h2 && held < 10) begin
      if (mem_valid !== 1'b0) begin
        failures++; $display("FAIL flush_stale_valid: valid=%b, required 0", mem_valid);
      end
      @(negedge clk); held++;
    end
    checks++;
    if (held !== 3) begin failures++; $display("FAIL flush_hold: held %0d cycles, required 3", held); end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin
      failures++;
      $display("FAIL flush_new_addr: req=%b addr=%h, required req=1 addr=0100", mem_req, mem_addr);
    end
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_valid !== 1'b1 || mem !== bmem(16'h0100) || pc !== 32'h100) begin
      failures++;
      $display("FAIL flush_first_byte: valid=%b mem=%h pc=%h, required valid=1 mem=%h pc=100",
               mem_valid, mem, pc, bmem(16'h0100));
    end
  endtask

  task automatic test_underflow;
    int n;
    do_reset(3);
    pc_load = 1'b1; c_bus = 32'h0000_0020;
    @(negedge clk);
    pc_load = 1'b0; fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    checks++;
    if (fetch_miss !== 1'b1 || pc !== 32'h20 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL underflow_miss: miss=%b pc=%h valid=%b, required miss=1 pc=20 valid=0", fetch_miss, pc, mem_valid);
    end
    @(negedge clk);
    checks++;
    if (fetch_miss !== 1'b0) begin failures++; $display("FAIL underflow_pulse: miss=%b, required 0", fetch_miss); end
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_valid !== 1'b1 || mem !== bmem(16'h0020) || pc !== 32'h20) begin
      failures++;
      $display("FAIL underflow_deliver: valid=%b mem=%h pc=%h, required valid=1 mem=%h pc=20",
               mem_valid, mem, pc, bmem(16'h0020));
    end
  endtask

  task automatic test_wrap;
    logic [15:0] a;
    do_reset(0);
    pc_load = 1'b1; c_bus = 32'h1234_FFFE;
    @(negedge clk);
    pc_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || pc !== 32'h0000_FFFE) begin
        failures++;
        $display("FAIL wrap_addr[%0d]: req=%b addr=%h pc=%h, required req=1 addr=%h pc=0000fffe", i, mem_req, mem_addr, pc, a);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFE + 16'(i);
      checks++;
      if (mem_valid !== 1'b1 || mem !== bmem(a) || pc !== 32'h0000_FFFE + 32'(i)) begin
        failures++;
        $display("FAIL wrap_pop[%0d]: valid=%b mem=%h pc=%h, required valid=1 mem=%h pc=%h",
                 i, mem_valid, mem, pc, bmem(a), 32'h0000_FFFE + 32'(i));
      end
      fetch = (i < 4);
      @(negedge clk);
    end
    fetch = 1'b0;
  endtask

  task automatic test_async_reset;
    int n;
    do_reset(3);
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1 || pc !== 32'd1) begin
      failures++;
      $display("FAIL areset_setup: req=%b pc=%h, required req=1 pc=1", mem_req, pc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_valid !== 1'b0 || pc !== 32'd0 || mem_addr !== 16'h0) begin
      failures++;
      $display("FAIL areset_immediate: req=%b valid=%b pc=%h addr=%h, required all zero", mem_req, mem_valid, pc, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_refill: req=%b addr=%h valid=%b, required req=1 addr=0000 valid=0", mem_req, mem_addr, mem_valid);
    end
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem !== bmem(16'h0) || pc !== 32'd0) begin
      failures++;
      $display("FAIL areset_first_byte: mem=%h pc=%h, required mem=%h pc=0", mem, pc, bmem(16'h0));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_flush();
    test_underflow();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
